fft_agu: RTL and testbench
==========================

Name: fft_agu

Overview:
- Address-generation and sequencing controller for the in-place radix-2 DIT FFT datapath.
- Sits directly upstream of the butterfly: issues one butterfly per cycle by driving the read addresses for operands A/B (data RAM) and the twiddle ROM address.
- Drives the matching write-back addresses and enable after the fixed read+butterfly latency, so butterfly results land in place.
- Sequences all log2(N) stages, draining the pipeline between stages, and signals completion.

Parameters:
- N_LOG2, 5, log2 of FFT length N (default 32-point); L = N_LOG2.
- LAT, 2, cycles from rd_en/address issue to the butterfly outputs being valid at the RAM write port; must be >= 1.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  single-cycle request to begin a full FFT; honoured only in IDLE
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse after the final write-back of the last stage
- rd_en  output  1  read strobe for both data-RAM read ports
- adr_a  output  N_LOG2  read address, operand A
- adr_b  output  N_LOG2  read address, operand B
- tw_adr  output  N_LOG2-1  twiddle ROM address
- wr_en  output  1  write strobe for both data-RAM write ports
- wr_adr_a  output  N_LOG2  write address for A' (adr_a delayed LAT cycles)
- wr_adr_b  output  N_LOG2  write address for B' (adr_b delayed LAT cycles)
- stage  output  $clog2(N_LOG2)  current stage index, for debug and scaling control

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; stage=0; butterfly counter i=0.
  - All outputs 0, including delay-line valid bits, so no spurious write occurs after reset.
- States:
  - IDLE: outputs idle. start=1 -> RUN with s=0, i=0.
  - RUN: rd_en=1 every cycle. i increments each cycle. When i==N/2-1 -> DRAIN with drain count=0; i wraps to 0.
  - DRAIN: rd_en=0 for exactly LAT cycles. On the last DRAIN cycle: if s==L-1 -> DONE, else s+1 and -> RUN.
  - DONE: done=1 for one cycle, busy=0, then -> IDLE.
- Address rules, combinational from (i, s) while in RUN; addresses are 0 when rd_en=0:
  - adr_a = {i,1'b0} rotated left by s within N_LOG2 bits.
  - adr_b = {i,1'b1} rotated left by s within N_LOG2 bits.
  - tw_adr = i AND (all-ones << (L-1-s)), truncated to N_LOG2-1 bits.
- Write-back: wr_en, wr_adr_a, wr_adr_b are rd_en, adr_a, adr_b delayed by exactly LAT cycles through registered delay stages. Write addresses are 0 when wr_en=0.
- Hazard rule: the last write of stage s occurs in the final DRAIN cycle. The first read of stage s+1 occurs on the next cycle, which the synchronous-write RAM already reflects.
- Timing: if start is sampled at edge 0, the first RUN cycle is cycle 1. done is high in cycle 1 + L*(N/2+LAT). For defaults this is cycle 91.
- Boundary conditions:
  - start while busy or in DONE: ignored, no restart.
  - start held high: a new FFT starts only on return to IDLE.
  - reset asserted mid-RUN or mid-DRAIN: the operation is aborted, pending writes are discarded, and the block is in IDLE on release.
- busy = (state==RUN or state==DRAIN).

Decomposition:
- fft_pkg:
  - state typedef enum {IDLE, RUN, DRAIN, DONE}
  - default N_LOG2 constant
  - rotl function for N_LOG2-bit rotate
- Sub-module fft_wb_delay: a parameterised LAT-deep register pipeline of {valid, adr_a, adr_b} with async active-low clear; produces wr_en/wr_adr_a/wr_adr_b.

Test Plan:
- Address pattern, stage 0 (defaults, start pulse): at i=3 -> adr_a=6, adr_b=7, tw_adr=0. Stage 1, i=3 -> adr_a=12, adr_b=14, tw_adr=0. Stage 4, i=3 -> adr_a=3, adr_b=19, tw_adr=3.
- Latency and write-back: every wr_en pulse appears exactly 2 cycles after its rd_en, with identical addresses. Exactly 80 writes total. Each stage writes all addresses 0..31 exactly once.
- Stage sequencing: 16 rd_en cycles, then 2 idle cycles, per stage. stage counts 0..4. done pulses once in cycle 91 after start. busy deasserts in the same cycle.
- Start while busy: pulse start at cycle 20 -> no change to addresses or timing; done is still at 91 and there is a single done.
- Reset mid-operation: assert reset at cycle 40 for 2 cycles -> all outputs 0 immediately, no wr_en afterwards, no done. A new start then produces a full correct run.
- Parameter sweep N_LOG2=3, LAT=1: 4 reads per stage with 1 drain cycle. Stage 2, i=1 -> adr_a=1, adr_b=5, tw_adr=1. done at cycle 1+3*5=16.

Source files
------------

// File: rtl/fft_pkg.sv
// fft_pkg: shared definitions for the radix-2 DIT FFT address generator.
//   - fft_state_e : sequencer states (IDLE, RUN, DRAIN, DONE)
//   - FFT_N_LOG2_DEF : default log2 of the transform length
//   - rotl() : rotate-left of the low w bits of a ROT_W-bit word
package fft_pkg;

    localparam int FFT_N_LOG2_DEF = 5;

    // Working width of rotl(); any N_LOG2 up to ROT_W is supported.
    localparam int ROT_W  = 32;
    localparam int ROT_IW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } fft_state_e;

    // Rotate the low w bits of v left by sh positions. Bits at or above w
    // are returned as zero. w is a constant at every call site, so this
    // unrolls into pure wiring.
    function automatic logic [ROT_W-1:0] rotl(input logic [ROT_W-1:0] v,
                                              input int unsigned       sh,
                                              input int unsigned       w);
        logic [ROT_W-1:0]  r;
        logic [ROT_IW-1:0] src;
        logic [ROT_IW-1:0] dst;
        r = '0;
        for (int unsigned k = 0; k < ROT_W; k++) begin
            if (k < w) begin
                src    = ROT_IW'(k);
                dst    = ROT_IW'((k + sh) % w);
                r[dst] = v[src];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// fft_wb_delay: LAT-deep register pipeline carrying {valid, adr_a, adr_b}
// from the read side to the write side of the butterfly datapath.
//   clk_i     in   clock
//   rst_ni    in   asynchronous active-low clear of every stage
//   valid_i   in   read strobe entering the pipeline
//   adr_a_i   in   operand A address entering the pipeline
//   adr_b_i   in   operand B address entering the pipeline
//   valid_o   out  write strobe, valid_i delayed by LAT cycles
//   adr_a_o   out  A' write address (0 whenever valid_o is low)
//   adr_b_o   out  B' write address (0 whenever valid_o is low)
module fft_wb_delay #(
    parameter int AW  = 5,
    parameter int LAT = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    input  logic [AW-1:0] adr_a_i,
    input  logic [AW-1:0] adr_b_i,
    output logic          valid_o,
    output logic [AW-1:0] adr_a_o,
    output logic [AW-1:0] adr_b_o
);

    logic [LAT-1:0] v_q;
    logic [AW-1:0]  a_q [LAT];
    logic [AW-1:0]  b_q [LAT];

    // Valid bits are cleared with the addresses so an aborted FFT never
    // leaves a write in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            v_q[0] <= valid_i;
            a_q[0] <= adr_a_i;
            b_q[0] <= adr_b_i;
            for (int k = 1; k < LAT; k++) begin
                v_q[k] <= v_q[k-1];
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
        end
    end

    assign valid_o = v_q[LAT-1];
    assign adr_a_o = v_q[LAT-1] ? a_q[LAT-1] : '0;
    assign adr_b_o = v_q[LAT-1] ? b_q[LAT-1] : '0;

endmodule

// File: rtl/fft_agu.sv
// fft_agu: address generator / sequencer for an in-place radix-2 DIT FFT.
// Issues one butterfly per cycle for N/2 cycles per stage, drains the
// read-to-write latency between stages, and pulses done at the end.
//   clk       in   clock, all state on the rising edge
//   reset     in   asynchronous active-low reset
//   start     in   begin a full FFT (only acted on in IDLE)
//   busy      out  high while running or draining
//   done      out  one-cycle pulse after the last write-back
//   rd_en     out  read strobe for both data-RAM read ports
//   adr_a     out  operand A read address
//   adr_b     out  operand B read address
//   tw_adr    out  twiddle ROM address
//   wr_en     out  write strobe, rd_en delayed LAT cycles
//   wr_adr_a  out  A' write address, adr_a delayed LAT cycles
//   wr_adr_b  out  B' write address, adr_b delayed LAT cycles
//   stage     out  current stage index
// Strobes are plain qualifiers: an address is meaningful only in a cycle
// where its strobe is high, and is driven to 0 otherwise. There is no
// back-pressure; the datapath accepts one butterfly every cycle.
module fft_agu
    import fft_pkg::*;
#(
    parameter int N_LOG2 = FFT_N_LOG2_DEF,
    parameter int LAT    = 2,
    localparam int SW    = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1,
    localparam int DW    = (LAT > 1) ? $clog2(LAT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [N_LOG2-1:0] adr_a,
    output logic [N_LOG2-1:0] adr_b,
    output logic [N_LOG2-2:0] tw_adr,
    output logic              wr_en,
    output logic [N_LOG2-1:0] wr_adr_a,
    output logic [N_LOG2-1:0] wr_adr_b,
    output logic [SW-1:0]     stage
);

    localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);
    localparam logic [DW-1:0] D_LAST = DW'(LAT - 1);

    fft_state_e        state_q, state_d;
    logic [N_LOG2-2:0] i_q, i_d;      // butterfly index within a stage
    logic [SW-1:0]     s_q, s_d;      // stage index
    logic [DW-1:0]     d_q, d_d;      // drain cycle count

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            s_q     <= '0;
            d_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            s_q     <= s_d;
            d_q     <= d_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        s_d     = s_q;
        d_d     = d_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = '0;
                    s_d     = '0;
                end
            end
            RUN: begin
                // i_q all ones is the last butterfly (N/2-1) of the stage.
                if (i_q == '1) begin
                    state_d = DRAIN;
                    i_d     = '0;
                    d_d     = '0;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            DRAIN: begin
                // The final drain cycle carries the stage's last write, so
                // the next stage's first read already sees it in the RAM.
                if (d_q == D_LAST) begin
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                    end else begin
                        s_d     = s_q + 1'b1;
                        state_d = RUN;
                    end
                end else begin
                    d_d = d_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                s_d     = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------
    assign rd_en = (state_q == RUN);
    assign busy  = (state_q == RUN) || (state_q == DRAIN);
    assign done  = (state_q == DONE);
    assign stage = s_q;

    // ------------------------------------------------------------------
    // Read / twiddle address generation
    // ------------------------------------------------------------------
    // Stage s pairs addresses differing in bit s: the pair index i with
    // the pair bit appended at the LSB, rotated left by s, puts the pair
    // bit at position s and i's bits around it.
    logic [ROT_W-1:0]  pair_a, pair_b;
    logic [N_LOG2-1:0] rot_a, rot_b;
    logic [N_LOG2-2:0] tw_mask;
    int                tw_sh;

    always_comb begin
        pair_a                 = '0;
        pair_b                 = '0;
        pair_a[N_LOG2-1:0]     = {i_q, 1'b0};
        pair_b[N_LOG2-1:0]     = {i_q, 1'b1};
        rot_a                  = N_LOG2'(rotl(pair_a, 32'(s_q), N_LOG2));
        rot_b                  = N_LOG2'(rotl(pair_b, 32'(s_q), N_LOG2));
        // Twiddle index keeps only the top s bits of i: stage 0 uses W^0
        // throughout, the last stage uses every twiddle.
        tw_sh                  = N_LOG2 - 1 - int'(s_q);
        tw_mask                = {(N_LOG2-1){1'b1}} << tw_sh;
    end

    assign adr_a  = rd_en ? rot_a : '0;
    assign adr_b  = rd_en ? rot_b : '0;
    assign tw_adr = rd_en ? (i_q & tw_mask) : '0;

    // ------------------------------------------------------------------
    // Write-back alignment
    // ------------------------------------------------------------------
    fft_wb_delay #(
        .AW  (N_LOG2),
        .LAT (LAT)
    ) u_wb_delay (
        .clk_i   (clk),
        .rst_ni  (reset),
        .valid_i (rd_en),
        .adr_a_i (adr_a),
        .adr_b_i (adr_b),
        .valid_o (wr_en),
        .adr_a_o (wr_adr_a),
        .adr_b_o (wr_adr_b)
    );

endmodule

// File: tb/tb_fft_agu.sv
module tb_fft_agu;

    localparam int MAXC = 110;
    localparam int NF   = 10;
    localparam int F_RD = 0, F_A = 1, F_B = 2, F_TW = 3, F_BUSY = 4;
    localparam int F_DONE = 5, F_WR = 6, F_WA = 7, F_WB = 8, F_STG = 9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start0, start1;

    // Default instance: N_LOG2=5, LAT=2
    logic       busy0, done0, rd0, wr0;
    logic [4:0] a0, b0, wa0, wb0;
    logic [3:0] tw0;
    logic [2:0] stg0;

    // Sweep instance: N_LOG2=3, LAT=1
    logic       busy1, done1, rd1, wr1;
    logic [2:0] a1, b1, wa1, wb1;
    logic [1:0] tw1;
    logic [1:0] stg1;

    fft_agu #(.N_LOG2(5), .LAT(2)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .busy(busy0), .done(done0),
        .rd_en(rd0), .adr_a(a0), .adr_b(b0), .tw_adr(tw0), .wr_en(wr0),
        .wr_adr_a(wa0), .wr_adr_b(wb0), .stage(stg0)
    );

    fft_agu #(.N_LOG2(3), .LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .done(done1),
        .rd_en(rd1), .adr_a(a1), .adr_b(b1), .tw_adr(tw1), .wr_en(wr1),
        .wr_adr_a(wa1), .wr_adr_b(wb1), .stage(stg1)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cap [2][NF][MAXC+1];
    logic [47:0] exp_q[$];   // {due cycle, wr_adr_a, wr_adr_b}

    typedef struct {
        int dut; int cyc; int rd; int a; int b; int tw;
        int stg; int busy; int done; int wr; int wa; int wb;
    } vec_t;

    vec_t vecs[16];

    string fname [NF] = '{"rd_en", "adr_a", "adr_b", "tw_adr", "busy",
                          "done", "wr_en", "wr_adr_a", "wr_adr_b", "stage"};

    task automatic chk(input string name, input int c, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic sample(input int c);
        cap[0][F_RD][c] = int'(rd0);   cap[1][F_RD][c] = int'(rd1);
        cap[0][F_A][c] = int'(a0);     cap[1][F_A][c] = int'(a1);
        cap[0][F_B][c] = int'(b0);     cap[1][F_B][c] = int'(b1);
        cap[0][F_TW][c] = int'(tw0);   cap[1][F_TW][c] = int'(tw1);
        cap[0][F_BUSY][c] = int'(busy0); cap[1][F_BUSY][c] = int'(busy1);
        cap[0][F_DONE][c] = int'(done0); cap[1][F_DONE][c] = int'(done1);
        cap[0][F_WR][c] = int'(wr0);   cap[1][F_WR][c] = int'(wr1);
        cap[0][F_WA][c] = int'(wa0);   cap[1][F_WA][c] = int'(wa1);
        cap[0][F_WB][c] = int'(wb0);   cap[1][F_WB][c] = int'(wb1);
        cap[0][F_STG][c] = int'(stg0); cap[1][F_STG][c] = int'(stg1);
    endtask

    // ---------------- driver ----------------
    // Start is sampled at edge 0; cycle c is the interval after edge c-1.
    // extra_start > 0 re-asserts start during that cycle.
    task automatic run_capture(input int sel, input int ncyc, input int extra_start);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c == extra_start) begin
                if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
            end
            @(negedge clk);
            sample(c);
            @(posedge clk);
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int brot(input int x, input int s, input int l);
        return ((x << s) | (x >> (l - s))) & ((1 << l) - 1);
    endfunction

    task automatic apply_table(input int d);
        for (int k = 0; k < 16; k++) begin
            if (vecs[k].dut == d && vecs[k].cyc > 0) begin
                int c;
                c = vecs[k].cyc;
                chk("tbl_rd_en", c, cap[d][F_RD][c], vecs[k].rd);
                chk("tbl_adr_a", c, cap[d][F_A][c], vecs[k].a);
                chk("tbl_adr_b", c, cap[d][F_B][c], vecs[k].b);
                chk("tbl_tw_adr", c, cap[d][F_TW][c], vecs[k].tw);
                if (vecs[k].stg >= 0) chk("tbl_stage", c, cap[d][F_STG][c], vecs[k].stg);
                chk("tbl_busy", c, cap[d][F_BUSY][c], vecs[k].busy);
                chk("tbl_done", c, cap[d][F_DONE][c], vecs[k].done);
                chk("tbl_wr_en", c, cap[d][F_WR][c], vecs[k].wr);
                chk("tbl_wr_adr_a", c, cap[d][F_WA][c], vecs[k].wa);
                chk("tbl_wr_adr_b", c, cap[d][F_WB][c], vecs[k].wb);
            end
        end
    endtask

    // Whole-run check against the model plus the write-back scoreboard.
    task automatic check_run(input int d, input int l, input int lat, input int ncyc);
        int          half, per, done_c, nwr, ndone;
        logic [31:0] cov [8];
        logic [63:0] full;
        half   = 1 << (l - 1);
        per    = half + lat;
        done_c = 1 + l * per;
        full   = (64'd1 << (1 << l)) - 64'd1;
        nwr    = 0;
        ndone  = 0;
        exp_q.delete();
        for (int s = 0; s < 8; s++) cov[s] = '0;
        for (int c = 1; c <= ncyc; c++) begin
            int pos, s, i, run, ea, eb, etw;
            pos = (c - 1) % per;
            s   = (c - 1) / per;
            i   = pos;
            run = (c < done_c && pos < half) ? 1 : 0;
            ea  = run ? brot(2 * i, s, l) : 0;
            eb  = run ? brot(2 * i + 1, s, l) : 0;
            etw = run ? ((i >> (l - 1 - s)) << (l - 1 - s)) : 0;
            chk("run_rd_en", c, cap[d][F_RD][c], run);
            chk("run_adr_a", c, cap[d][F_A][c], ea);
            chk("run_adr_b", c, cap[d][F_B][c], eb);
            chk("run_tw_adr", c, cap[d][F_TW][c], etw);
            chk("run_busy", c, cap[d][F_BUSY][c], (c < done_c) ? 1 : 0);
            chk("run_done", c, cap[d][F_DONE][c], (c == done_c) ? 1 : 0);
            if (c < done_c) chk("run_stage", c, cap[d][F_STG][c], s);
            if (run) exp_q.push_back({16'(c + lat), 16'(ea), 16'(eb)});
            nwr   += cap[d][F_WR][c];
            ndone += cap[d][F_DONE][c];
            if (exp_q.size() > 0 && int'(exp_q[0][47:32]) == c) begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("wb_wr_en", c, cap[d][F_WR][c], 1);
                chk("wb_wr_adr_a", c, cap[d][F_WA][c], int'(e[31:16]));
                chk("wb_wr_adr_b", c, cap[d][F_WB][c], int'(e[15:0]));
                if (cap[d][F_WR][c] == 1) begin
                    cov[(c - lat - 1) / per][cap[d][F_WA][c]] = 1'b1;
                    cov[(c - lat - 1) / per][cap[d][F_WB][c]] = 1'b1;
                end
            end else begin
                chk("wb_idle_wr_en", c, cap[d][F_WR][c], 0);
                chk("wb_idle_wr_adr_a", c, cap[d][F_WA][c], 0);
                chk("wb_idle_wr_adr_b", c, cap[d][F_WB][c], 0);
            end
        end
        chk("write_count", ncyc, nwr, l * half);
        chk("done_count", ncyc, ndone, 1);
        chk("wb_pending", ncyc, exp_q.size(), 0);
        for (int s = 0; s < l; s++)
            chk("stage_coverage", s, int'(cov[s]), int'(full[31:0]));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nwr_after, ndone_after, nbusy_after;

        //            dut cyc rd  a   b tw stg bsy dn wr  wa  wb
        vecs[0]  = '{0,  1, 1,  0,  1, 0,  0, 1, 0, 0,  0,  0};
        vecs[1]  = '{0,  4, 1,  6,  7, 0,  0, 1, 0, 1,  2,  3};
        vecs[2]  = '{0, 17, 0,  0,  0, 0,  0, 1, 0, 1, 28, 29};
        vecs[3]  = '{0, 19, 1,  0,  2, 0,  1, 1, 0, 0,  0,  0};
        vecs[4]  = '{0, 22, 1, 12, 14, 0,  1, 1, 0, 1,  4,  6};
        vecs[5]  = '{0, 42, 1,  9, 13, 4,  2, 1, 0, 1, 24, 28};
        vecs[6]  = '{0, 58, 1, 17, 25, 2,  3, 1, 0, 1, 16, 24};
        vecs[7]  = '{0, 76, 1,  3, 19, 3,  4, 1, 0, 1,  1, 17};
        vecs[8]  = '{0, 90, 0,  0,  0, 0,  4, 1, 0, 1, 15, 31};
        vecs[9]  = '{0, 91, 0,  0,  0, 0, -1, 0, 1, 0,  0,  0};
        vecs[10] = '{0, 92, 0,  0,  0, 0, -1, 0, 0, 0,  0,  0};
        vecs[11] = '{1,  1, 1,  0,  1, 0,  0, 1, 0, 0,  0,  0};
        vecs[12] = '{1,  5, 0,  0,  0, 0,  0, 1, 0, 1,  6,  7};
        vecs[13] = '{1, 12, 1,  1,  5, 1,  2, 1, 0, 1,  0,  4};
        vecs[14] = '{1, 15, 0,  0,  0, 0,  2, 1, 0, 1,  3,  7};
        vecs[15] = '{1, 16, 0,  0,  0, 0, -1, 0, 1, 0,  0,  0};

        // Power-up reset: every output of both instances is 0.
        reset  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        #1;
        sample(0);
        for (int f = 0; f < NF; f++) begin
            chk({"reset_", fname[f]}, 0, cap[0][f][0], 0);
            chk({"reset1_", fname[f]}, 0, cap[1][f][0], 0);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        // Default full run: hand vectors, then the whole-run model.
        run_capture(0, 93, 0);
        apply_table(0);
        check_run(0, 5, 2, 93);

        // Start pulse at cycle 20 while busy must change nothing.
        repeat (3) @(posedge clk);
        run_capture(0, 93, 20);
        check_run(0, 5, 2, 93);

        // Reset during stage 2: outputs clear at once, no later writes.
        repeat (3) @(posedge clk);
        run_capture(0, 39, 0);
        reset = 1'b0;
        #1;
        sample(0);
        for (int f = 0; f < NF; f++)
            chk({"abort_", fname[f]}, 40, cap[0][f][0], 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        nwr_after   = 0;
        ndone_after = 0;
        nbusy_after = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            nwr_after   += int'(wr0);
            ndone_after += int'(done0);
            nbusy_after += int'(busy0);
        end
        chk("abort_no_writes", 0, nwr_after, 0);
        chk("abort_no_done", 0, ndone_after, 0);
        chk("abort_idle", 0, nbusy_after, 0);
        run_capture(0, 93, 0);
        check_run(0, 5, 2, 93);

        // Parameter sweep instance N_LOG2=3, LAT=1.
        repeat (3) @(posedge clk);
        run_capture(1, 17, 0);
        apply_table(1);
        check_run(1, 3, 1, 17);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
